// File: rtl/prewish_pattern_sequencer_pkg.sv
// prewish_pattern_sequencer_pkg: shared states and constants for the pattern sequencer
package prewish_pattern_sequencer_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, DWELL, BLANK} state_t;
  localparam int ROLL_STEPS = 8;
  localparam int ROLL_SHIFT = $clog2(ROLL_STEPS);
  localparam int DAT_W = 8;
endpackage

// File: rtl/prewish_pattern_sequencer_if.sv
// prewish_pattern_sequencer_if: host table/playback controls and blinky-facing outputs
interface prewish_pattern_sequencer_if #(
  parameter int DEPTH_BITS = 3,
  parameter int REP_BITS = 4
);
  import prewish_pattern_sequencer_pkg::*;
  logic i_wr_en;
  logic [DEPTH_BITS-1:0] i_wr_addr;
  logic [DAT_W-1:0] i_wr_pattern;
  logic [REP_BITS-1:0] i_wr_reps;
  logic i_start;
  logic [DEPTH_BITS:0] i_count;
  logic i_loop;
  logic i_stop;
  logic o_stb;
  logic [DAT_W-1:0] o_dat;
  logic o_busy;
  logic [DEPTH_BITS-1:0] o_index;
  logic o_done;
  modport master(
    output i_wr_en, i_wr_addr, i_wr_pattern, i_wr_reps, i_start, i_count, i_loop, i_stop,
    input o_stb, o_dat, o_busy, o_index, o_done
  );
  modport slave(
    input i_wr_en, i_wr_addr, i_wr_pattern, i_wr_reps, i_start, i_count, i_loop, i_stop,
    output o_stb, o_dat, o_busy, o_index, o_done
  );
endinterface

// File: rtl/prewish_dwell_timer.sv
// prewish_dwell_timer: counts reps full mask rotations after a load pulse, pulses expire on the last cycle
module prewish_dwell_timer
  import prewish_pattern_sequencer_pkg::*;
#(
  parameter int SYSCLK_DIV_BITS = 22,
  parameter int REP_BITS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic abort,
  input  logic load,
  input  logic [REP_BITS-1:0] reps,
  output logic expire
);
  localparam int W = REP_BITS + ROLL_SHIFT + SYSCLK_DIV_BITS;
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = abort ? '0 : load ? (W'(reps) << (ROLL_SHIFT + SYSCLK_DIV_BITS)) : cnt_q - W'(cnt_q != '0);
  assign expire = cnt_q == W'(1);
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/prewish_pattern_sequencer.sv
// prewish_pattern_sequencer: plays a host-written (pattern, reps) table into the blinky strobe/data inputs
module prewish_pattern_sequencer
  import prewish_pattern_sequencer_pkg::*;
#(
  parameter int SYSCLK_DIV_BITS = 22,
  parameter int DEPTH_BITS = 3,
  parameter int REP_BITS = 4
) (
  input logic CLK_I,
  input logic RST_I,
  prewish_pattern_sequencer_if.slave bus
);
  localparam int ENTRIES = 1 << DEPTH_BITS;
  logic [DAT_W-1:0] pat_q [ENTRIES];
  logic [REP_BITS-1:0] rep_q [ENTRIES];
  state_t state_q, state_d;
  logic [DEPTH_BITS-1:0] idx_q, idx_d, last_q, last_d;
  logic [REP_BITS-1:0] cur_q, cur_d;
  logic loop_q, loop_d, loaded_q, loaded_d, fin_q, fin_d;
  logic stb_q, stb_d, busy_q, busy_d, done_q, done_d;
  logic [DAT_W-1:0] dat_q, dat_d;
  logic [DEPTH_BITS:0] cnt_c;
  logic active, at_last, accept, expire;
  assign cnt_c = bus.i_count[DEPTH_BITS] ? {1'b1, {DEPTH_BITS{1'b0}}} : bus.i_count;
  assign active = state_q == FETCH || state_q == LOAD || state_q == DWELL;
  assign at_last = idx_q == last_q;
  assign accept = state_q == IDLE && bus.i_start && !bus.i_stop && cnt_c != '0;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    last_d = last_q;
    cur_d = cur_q;
    loop_d = loop_q;
    loaded_d = loaded_q;
    fin_d = fin_q;
    if (accept) begin
      state_d = FETCH;
      idx_d = '0;
      last_d = DEPTH_BITS'(cnt_c - 1'b1);
      loop_d = bus.i_loop;
      loaded_d = 1'b0;
      fin_d = 1'b0;
    end else if (active && bus.i_stop) begin
      state_d = BLANK;
    end else if (state_q == FETCH) begin
      if (fin_q) state_d = BLANK;
      else if (rep_q[idx_q] != '0) begin
        state_d = LOAD;
        loaded_d = 1'b1;
        cur_d = rep_q[idx_q];
      end else if (!at_last) idx_d = idx_q + 1'b1;
      else if (loop_q && loaded_q) begin
        idx_d = '0;
        loaded_d = 1'b0;
      end else state_d = BLANK;
    end else if (state_q == LOAD) begin
      state_d = DWELL;
    end else if (state_q == DWELL && expire) begin
      // a finished non-looping pass spends one more FETCH cycle before blanking
      state_d = FETCH;
      if (!at_last) idx_d = idx_q + 1'b1;
      else if (loop_q) begin
        idx_d = '0;
        loaded_d = 1'b0;
      end else fin_d = 1'b1;
    end else if (state_q == BLANK) begin
      state_d = IDLE;
    end
    stb_d = state_d == LOAD || state_d == BLANK;
    dat_d = state_d == LOAD ? pat_q[idx_q] : '0;
    busy_d = state_d != IDLE;
    done_d = state_q == BLANK;
  end
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q <= IDLE;
      idx_q <= '0;
      last_q <= '0;
      cur_q <= '0;
      loop_q <= 1'b0;
      loaded_q <= 1'b0;
      fin_q <= 1'b0;
      stb_q <= 1'b0;
      dat_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
        pat_q[i] <= '0;
        rep_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      last_q <= last_d;
      cur_q <= cur_d;
      loop_q <= loop_d;
      loaded_q <= loaded_d;
      fin_q <= fin_d;
      stb_q <= stb_d;
      dat_q <= dat_d;
      busy_q <= busy_d;
      done_q <= done_d;
      if (bus.i_wr_en) begin
        pat_q[bus.i_wr_addr] <= bus.i_wr_pattern;
        rep_q[bus.i_wr_addr] <= bus.i_wr_reps;
      end
    end
  end
  prewish_dwell_timer #(.SYSCLK_DIV_BITS(SYSCLK_DIV_BITS), .REP_BITS(REP_BITS)) u_timer (
    .clk(CLK_I),
    .rst(RST_I),
    .abort(active && bus.i_stop),
    .load(state_q == LOAD),
    .reps(cur_q),
    .expire(expire)
  );
  assign bus.o_stb = stb_q;
  assign bus.o_dat = dat_q;
  assign bus.o_busy = busy_q;
  assign bus.o_index = idx_q;
  assign bus.o_done = done_q;
endmodule
